iob_skid_buf: RTL
=================

// Module: iob_skid_buf
//
// PURPOSE
// - Two-entry elastic stage with valid/ready handshakes on both sides. It sits directly upstream of the
//   plain pipeline registers in the cache datapath (front-end request path, write-through buffer input).
// - Breaks the combinational ready path: s_ready_o is derived only from local state.
// - Sustains one transfer per cycle with one cycle of latency.
//
// PARAMETERS
// - DATA_W   default `IOB_SKID_BUF_DATA_W (32)  payload width in bits
// - RST_VAL  default `IOB_SKID_BUF_RST_VAL (0)  reset value of both data registers
//
// PORTS
// - clk_i      in   1       clock, all state updates on the rising edge
// - cke_i      in   1       clock enable; low = freeze all state, no handshakes
// - rst_i      in   1       synchronous reset, active-high
// - s_valid_i  in   1       upstream payload valid
// - s_data_i   in   DATA_W  upstream payload
// - s_ready_o  out  1       buffer can accept a payload
// - m_valid_o  out  1       downstream payload valid
// - m_data_o   out  DATA_W  downstream payload, driven directly from the main register
// - m_ready_i  in   1       downstream accepts the payload
// - level_o    out  2       occupancy: 0, 1 or 2
//
// BEHAVIOUR
// - Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
// - Reset priority: rst_i overrides cke_i.
// - Reset values: state EMPTY, main = skid = RST_VAL, m_valid_o = 0, level_o = 0, s_ready_o = cke_i.
// - Transfer definitions:
//   - in  = s_valid_i & s_ready_o
//   - out = m_valid_o & m_ready_i
// - Output gating (combinational):
//   - s_ready_o = cke_i & (state != FULL)
//   - m_valid_o = cke_i & (state != EMPTY)
// - States and transitions (evaluated only when cke_i = 1):
//   - EMPTY: in -> main <= s_data_i, go BUSY. Otherwise stay EMPTY.
//   - BUSY, in & !out: skid <= s_data_i, go FULL.
//   - BUSY, in & out: main <= s_data_i, stay BUSY (pass-through at full rate).
//   - BUSY, !in & out: go EMPTY. main keeps its stale value and is not cleared.
//   - BUSY, neither: hold.
//   - FULL, out: main <= skid, go BUSY. in is impossible (s_ready_o = 0).
//   - FULL, !out: hold.
// - level_o: EMPTY = 0, BUSY = 1, FULL = 2. It is registered, i.e. decoded from the state register.
// - Latency: a payload accepted in cycle N appears on m_data_o with m_valid_o = 1 in cycle N+1.
// - Stability: while m_valid_o & !m_ready_i, m_data_o must not change.
// - Ordering: strict FIFO order; no payload is dropped or duplicated.
// - cke_i = 0: both handshake outputs read 0, so no transfer can complete. All registers hold.
// - Reset mid-operation: any buffered payloads are discarded. Outputs take reset values in the next cycle.
// - Protocol rule: s_valid_i may drop without a transfer (no upstream hold requirement). The block
//   itself never drops m_valid_o without out, except on reset or cke_i = 0.
//
// STRUCTURE
// - Shared config header iob_skid_buf_conf.vh:
//   - `IOB_SKID_BUF_DATA_W, `IOB_SKID_BUF_RST_VAL
//   - 2-bit state encodings EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2
//   - level_o is the state code itself
// - Sub-module iob_reg_re (sync reset + enable register) is instantiated three times:
//   - main data register, DATA_W bits
//   - skid data register, DATA_W bits
//   - 2-bit state register
// - All next-state and enable logic lives in one combinational always block in this module.
//
// TESTING
// 1 Reset: assert rst_i for 2 cycles with s_valid_i = 1 -> m_valid_o = 0, level_o = 0, m_data_o = 0,
//   s_ready_o = 1 after release.
// 2 Streaming: push 0x1..0x10 back-to-back with m_ready_i = 1 -> each word appears 1 cycle later, in
//   order. level_o stays 1 and s_ready_o stays 1 throughout.
// 3 Backpressure: push 0xA, 0xB with m_ready_i = 0 -> level_o = 2, s_ready_o = 0, m_data_o holds 0xA.
//   Then raise m_ready_i -> 0xA, then 0xB, then level_o = 0.
// 4 Simultaneous in/out in FULL: with m_ready_i = 1 and s_valid_i = 1 -> one cycle drains to BUSY,
//   then pass-through. No word is lost (scoreboard check).
// 5 Clock enable: hold cke_i = 0 for 3 cycles in the BUSY state -> m_valid_o = s_ready_o = 0 and state
//   unchanged. After cke_i returns to 1, m_data_o still shows the same word.
// 6 Reset mid-operation: assert rst_i while FULL -> next cycle level_o = 0, m_valid_o = 0. Both buffered
//   words never appear. Finish with random valid/ready traffic (10k cycles) plus a FIFO-order scoreboard.

Source files
------------

// File: rtl/iob_skid_buf_pkg.sv
// Shared constants and state encoding for the two-entry skid buffer.
// The occupancy output is the state code itself, so the encoding is load-bearing.
package iob_skid_buf_pkg;

  localparam int IOB_SKID_BUF_DATA_W  = 32;
  localparam int IOB_SKID_BUF_RST_VAL = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  function automatic logic [1:0] level_of(input state_e s);
    return s;
  endfunction

endpackage

// File: rtl/iob_skid_buf_if.sv
// Upstream/downstream valid-ready bundle for iob_skid_buf.
// slave = the buffer side, master = the side that drives payloads and ready.
interface iob_skid_buf_if
  import iob_skid_buf_pkg::*;
#(
  parameter int DATA_W = IOB_SKID_BUF_DATA_W
);
  logic              s_valid_i;
  logic [DATA_W-1:0] s_data_i;
  logic              s_ready_o;
  logic              m_valid_o;
  logic [DATA_W-1:0] m_data_o;
  logic              m_ready_i;

  modport slave (
    input  s_valid_i, s_data_i, m_ready_i,
    output s_ready_o, m_valid_o, m_data_o
  );

  modport master (
    output s_valid_i, s_data_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_data_o
  );
endinterface

// File: rtl/iob_skid_buf_reg_re.sv
// Register with synchronous active-high reset and clock/load enables.
// Reset wins over both enables.
module iob_reg_re #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_cke,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)             r_q <= RST_VAL;
    else if (i_cke && i_en) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/iob_skid_buf.sv
// Two-entry elastic stage: full-rate pass-through, one cycle latency, and a
// s_ready_o that depends only on local state so the downstream ready path is cut.
module iob_skid_buf
  import iob_skid_buf_pkg::*;
#(
  parameter int              DATA_W  = IOB_SKID_BUF_DATA_W,
  parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(IOB_SKID_BUF_RST_VAL)
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  rst_i,
  iob_skid_buf_if.slave         bus,
  output logic [1:0]            level_o
);
  logic [1:0]        w_state_q;
  logic [1:0]        w_state_d;
  state_e            w_state;
  state_e            w_state_nxt;
  logic              w_in;
  logic              w_out;
  logic              w_s_ready;
  logic              w_m_valid;
  logic [1:0]        w_level;
  logic              w_main_en;
  logic              w_skid_en;
  logic [DATA_W-1:0] w_main_d;
  logic [DATA_W-1:0] w_main_q;
  logic [DATA_W-1:0] w_skid_q;

  assign w_state   = state_e'(w_state_q);
  assign w_state_d = w_state_nxt;
  assign w_in      = bus.s_valid_i & w_s_ready;
  assign w_out     = w_m_valid & bus.m_ready_i;

  iob_reg_re #(.W(2), .RST_VAL(ST_EMPTY)) u_state (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_cke (cke_i),
    .i_en  (1'b1),
    .i_d   (w_state_d),
    .o_q   (w_state_q)
  );

  iob_reg_re #(.W(DATA_W), .RST_VAL(RST_VAL)) u_main (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_cke (cke_i),
    .i_en  (w_main_en),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  iob_reg_re #(.W(DATA_W), .RST_VAL(RST_VAL)) u_skid (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_cke (cke_i),
    .i_en  (w_skid_en),
    .i_d   (bus.s_data_i),
    .o_q   (w_skid_q)
  );

  // Next state and register loads; in/out are already zero while cke_i is low.
  always_comb begin
    w_state_nxt = w_state;
    w_main_en   = 1'b0;
    w_skid_en   = 1'b0;
    w_main_d    = bus.s_data_i;
    case (w_state)
      ST_EMPTY: begin
        if (w_in) begin
          w_main_en   = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_in && !w_out) begin
          w_skid_en   = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_in && w_out) begin
          w_main_en   = 1'b1;
        end else if (w_out) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out) begin
          w_main_en   = 1'b1;
          w_main_d    = w_skid_q;
          w_state_nxt = ST_BUSY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_comb begin
    w_s_ready = cke_i & (w_state != ST_FULL);
    w_m_valid = cke_i & (w_state != ST_EMPTY);
    w_level   = level_of(w_state);
  end

  assign bus.s_ready_o = w_s_ready;
  assign bus.m_valid_o = w_m_valid;
  assign bus.m_data_o  = w_main_q;
  assign level_o       = w_level;
endmodule
